// File: rtl/pc_sequencer_pkg.sv
// Shared opcodes, FSM state encoding and fault codes for the PC sequencer.
package pc_sequencer_pkg;

    localparam logic [4:0] OP_JR   = 5'b01101;
    localparam logic [4:0] OP_JPC  = 5'b01110;
    localparam logic [4:0] OP_BRFL = 5'b01111;
    localparam logic [4:0] OP_CALL = 5'b10000;
    localparam logic [4:0] OP_RET  = 5'b10001;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_REDIRECT = 2'd1;
    localparam logic [1:0] ST_FAULT    = 2'd2;

    localparam logic [1:0] FC_NONE      = 2'b00;
    localparam logic [1:0] FC_OVERFLOW  = 2'b01;
    localparam logic [1:0] FC_UNDERFLOW = 2'b10;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack with a registered top-of-stack so RET never sees a
// combinational path from the pop decision.
module ras_stack #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_depth;
    logic [WIDTH-1:0] r_top;
    logic [PW-1:0]    w_below_full;
    logic [IW-1:0]    w_wr_idx;
    logic [IW-1:0]    w_below_idx;

    assign w_wr_idx     = r_depth[IW-1:0];
    assign w_below_full = r_depth - PW'(2);
    assign w_below_idx  = w_below_full[IW-1:0];

    // Caller guarantees push only when !full and pop only when !empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_depth <= '0;
            r_top   <= '0;
        end else if (push) begin
            r_mem[w_wr_idx] <= data_in;
            r_top           <= data_in;
            r_depth         <= r_depth + PW'(1);
        end else if (pop) begin
            r_top   <= r_mem[w_below_idx];
            r_depth <= r_depth - PW'(1);
        end
    end

    assign top   = r_top;
    assign depth = r_depth;
    assign full  = (r_depth == PW'(DEPTH));
    assign empty = (r_depth == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: resolves control-flow targets, drives the one-cycle
// redirect pulse and traps return-stack overflow/underflow into FAULT.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int          DWIDTH   = 32,
    parameter int          AWIDTH   = 15,
    parameter int          DEPTH    = 32,
    parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       instr_valid,
    input  logic [DWIDTH-1:0]          instr,
    input  logic [AWIDTH-1:0]          instr_pc,
    input  logic [DWIDTH-1:0]          rd,
    input  logic [DWIDTH-1:0]          immediate,
    input  logic                       cond_flag,
    input  logic                       stall_in,
    input  logic                       fault_clr,
    output logic [AWIDTH-1:0]          pc,
    output logic                       redirect,
    output logic                       fault,
    output logic [1:0]                 fault_code,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty
);
    logic [1:0]        r_state;
    logic [AWIDTH-1:0] r_pc;
    logic              r_redirect;
    logic              r_fault;
    logic [1:0]        r_fault_code;

    logic [4:0]        w_op;
    logic              w_accept;
    logic              w_taken;
    logic              w_ovf;
    logic              w_unf;
    logic              w_push;
    logic              w_pop;
    logic [DWIDTH-1:0] w_jpc_sum;
    logic [AWIDTH-1:0] w_target;
    logic [AWIDTH-1:0] w_ret_addr;
    logic [AWIDTH-1:0] w_top;
    logic              w_full;
    logic              w_empty;

    assign w_op       = instr[DWIDTH-1 -: 5];
    assign w_accept   = instr_valid && (r_state == ST_RUN) && !stall_in;
    assign w_jpc_sum  = immediate + rd + DWIDTH'(1);
    assign w_ret_addr = instr_pc + AWIDTH'(1);

    assign w_ovf  = w_accept && (w_op == OP_CALL) && w_full;
    assign w_unf  = w_accept && (w_op == OP_RET)  && w_empty;
    assign w_push = w_accept && (w_op == OP_CALL) && !w_full;
    assign w_pop  = w_accept && (w_op == OP_RET)  && !w_empty;

    always_comb begin
        w_taken  = 1'b0;
        w_target = rd[AWIDTH-1:0];
        if (w_accept) begin
            case (w_op)
                OP_JR:   w_taken = 1'b1;
                OP_BRFL: w_taken = cond_flag;
                OP_JPC: begin
                    w_taken  = 1'b1;
                    w_target = w_jpc_sum[AWIDTH-1:0];
                end
                OP_CALL: w_taken = !w_full;
                OP_RET: begin
                    w_taken  = !w_empty;
                    w_target = w_top;
                end
                default: w_taken = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_redirect   <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // Faults freeze the PC rather than taking the branch.
                    if (w_ovf || w_unf) begin
                        r_state      <= ST_FAULT;
                        r_fault      <= 1'b1;
                        r_fault_code <= w_ovf ? FC_OVERFLOW : FC_UNDERFLOW;
                    end else if (w_taken) begin
                        r_state    <= ST_REDIRECT;
                        r_pc       <= w_target;
                        r_redirect <= 1'b1;
                    end else if (!stall_in) begin
                        r_pc <= r_pc + AWIDTH'(1);
                    end
                end
                ST_REDIRECT: begin
                    r_state    <= ST_RUN;
                    r_redirect <= 1'b0;
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        r_state      <= ST_RUN;
                        r_fault      <= 1'b0;
                        r_fault_code <= FC_NONE;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    ras_stack #(
        .WIDTH (AWIDTH),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .pop     (w_pop),
        .data_in (w_ret_addr),
        .top     (w_top),
        .depth   (depth),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign pc         = r_pc;
    assign redirect   = r_redirect;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;
    assign full       = w_full;
    assign empty      = w_empty;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, stall, JPC/BRFL/CALL/RET,
// stack overflow/underflow faults and reset out of FAULT.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic [14:0] instr_pc;
    logic [31:0] rd;
    logic [31:0] immediate;
    logic        cond_flag;
    logic        stall_in;
    logic        fault_clr;
    logic [14:0] pc;
    logic        redirect;
    logic        fault;
    logic [1:0]  fault_code;
    logic [5:0]  depth;
    logic        full;
    logic        empty;

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .rd          (rd),
        .immediate   (immediate),
        .cond_flag   (cond_flag),
        .stall_in    (stall_in),
        .fault_clr   (fault_clr),
        .pc          (pc),
        .redirect    (redirect),
        .fault       (fault),
        .fault_code  (fault_code),
        .depth       (depth),
        .full        (full),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] r, input logic [31:0] imm,
                         input logic [14:0] ipc, input logic cf);
        instr_valid = 1'b1;
        instr       = {op, 27'd0};
        rd          = r;
        immediate   = imm;
        instr_pc    = ipc;
        cond_flag   = cf;
    endtask

    task automatic idle();
        instr_valid = 1'b0;
        instr       = '0;
        cond_flag   = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"}, 32'(pc), 32'h0);
        check({tag, "_redirect"}, 32'(redirect), 32'h0);
        check({tag, "_fault"}, 32'(fault), 32'h0);
        check({tag, "_code"}, 32'(fault_code), 32'h0);
        check({tag, "_depth"}, 32'(depth), 32'h0);
        check({tag, "_empty"}, 32'(empty), 32'h1);
        check({tag, "_full"}, 32'(full), 32'h0);
    endtask

    initial begin
        rst = 1'b1; stall_in = 1'b0; fault_clr = 1'b0;
        instr_pc = '0; rd = '0; immediate = '0;
        idle();
        step(); step();
        check_reset_state("reset");

        // Sequential fetch and stall hold
        rst = 1'b0;
        step(); check("seq_pc1", 32'(pc), 32'h1);
        step(); check("seq_pc2", 32'(pc), 32'h2);
        check("seq_noredir", 32'(redirect), 32'h0);
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check("stall_hold", 32'(pc), 32'h2);
        end
        stall_in = 1'b0;

        // Stalled branch must not be accepted
        stall_in = 1'b1;
        issue(5'b01101, 32'h300, 0, 15'h2, 1'b0);
        step(); check("stall_jr_pc", 32'(pc), 32'h2);
        check("stall_jr_redir", 32'(redirect), 32'h0);
        stall_in = 1'b0;
        idle();

        // JPC: 0x5 + 0x10 + 1 = 0x16; wrong-path JR in REDIRECT is dropped
        issue(5'b01110, 32'h10, 32'h5, 15'h2, 1'b0);
        step(); check("jpc_pc", 32'(pc), 32'h16);
        check("jpc_redir", 32'(redirect), 32'h1);
        issue(5'b01101, 32'h55, 0, 15'h16, 1'b0);
        step(); check("jpc_hold_pc", 32'(pc), 32'h16);
        check("jpc_redir_low", 32'(redirect), 32'h0);
        idle();
        step(); check("jpc_next_pc", 32'(pc), 32'h17);

        // JPC target wraps modulo 2^15
        issue(5'b01110, 32'h0000_7FFF, 32'h0001_0005, 15'h17, 1'b0);
        step(); check("jpc_wrap_pc", 32'(pc), 32'h5);
        idle();
        step(); step(); check("jpc_wrap_next", 32'(pc), 32'h6);

        // BRFL not taken then taken
        issue(5'b01111, 32'h40, 0, 15'h6, 1'b0);
        step(); check("brfl_nt_pc", 32'(pc), 32'h7);
        check("brfl_nt_redir", 32'(redirect), 32'h0);
        issue(5'b01111, 32'h40, 0, 15'h7, 1'b1);
        step(); check("brfl_t_pc", 32'(pc), 32'h40);
        check("brfl_t_redir", 32'(redirect), 32'h1);
        idle();
        step(); step(); check("brfl_t_next", 32'(pc), 32'h41);

        // CALL from 0x7FFF pushes wrapped 0x0000; RET returns there
        issue(5'b10000, 32'h100, 0, 15'h7FFF, 1'b0);
        step(); check("call_pc", 32'(pc), 32'h100);
        check("call_depth", 32'(depth), 32'h1);
        check("call_redir", 32'(redirect), 32'h1);
        idle();
        step();
        issue(5'b10001, 0, 0, 15'h100, 1'b0);
        step(); check("ret_pc", 32'(pc), 32'h0);
        check("ret_depth", 32'(depth), 32'h0);
        check("ret_empty", 32'(empty), 32'h1);
        idle();
        step();

        // Fill the stack with 32 CALLs
        for (int i = 0; i < 32; i++) begin
            issue(5'b10000, 32'h200 + 32'(i), 0, 15'(i * 2), 1'b0);
            step();
            idle();
            step();
        end
        check("fill_full", 32'(full), 32'h1);
        check("fill_depth", 32'(depth), 32'd32);
        check("fill_pc", 32'(pc), 32'h21F);

        // Overflow
        issue(5'b10000, 32'h500, 0, 15'h21F, 1'b0);
        step(); check("ovf_fault", 32'(fault), 32'h1);
        check("ovf_code", 32'(fault_code), 32'h1);
        check("ovf_depth", 32'(depth), 32'd32);
        check("ovf_pc", 32'(pc), 32'h21F);
        check("ovf_redir", 32'(redirect), 32'h0);
        issue(5'b01101, 32'h123, 0, 15'h21F, 1'b0);
        step(); check("fault_ignore_pc", 32'(pc), 32'h21F);
        check("fault_sticky", 32'(fault), 32'h1);
        idle();
        fault_clr = 1'b1;
        step(); check("clr_fault", 32'(fault), 32'h0);
        check("clr_code", 32'(fault_code), 32'h0);
        check("clr_pc", 32'(pc), 32'h21F);
        fault_clr = 1'b0;
        step(); check("clr_run_pc", 32'(pc), 32'h220);

        // 32 RETs in LIFO order: CALL i pushed i*2+1
        for (int i = 31; i >= 0; i--) begin
            issue(5'b10001, 0, 0, 15'h0, 1'b0);
            step();
            check("lifo_ret", 32'(pc), 32'(i * 2 + 1));
            idle();
            step();
        end
        check("lifo_empty", 32'(empty), 32'h1);
        check("lifo_depth", 32'(depth), 32'h0);

        // Underflow, then reset out of FAULT
        issue(5'b10001, 0, 0, 15'h1, 1'b0);
        step(); check("unf_fault", 32'(fault), 32'h1);
        check("unf_code", 32'(fault_code), 32'h2);
        check("unf_pc", 32'(pc), 32'h1);
        idle();
        issue(5'b10000, 32'h700, 0, 15'h1, 1'b0);
        step();
        idle();
        rst = 1'b1;
        step();
        check_reset_state("fault_reset");
        rst = 1'b0;
        step(); check("post_reset_pc", 32'(pc), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
